// File: rtl/reg_scoreboard.sv
// reg_scoreboard: producer-side hazard tracker for the 5-stage pipeline.
// Tracks outstanding GPR writers and stalls ID issue on unresolved RAW hazards or resource limits.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int TAG_W = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_wen,
    input  logic [4:0]       issue_rd,
    input  logic [1:0]       issue_kind,
    input  logic [4:0]       src_rj,
    input  logic [4:0]       src_rk,
    input  logic [4:0]       src_rd,
    input  logic             use_rj,
    input  logic             use_rk,
    input  logic             use_rd,
    output logic             stall,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             rdy_valid,
    input  logic [TAG_W-1:0] rdy_tag,
    input  logic [4:0]       rdy_rd,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [TAG_W:0]   inflight
);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [TAG_W:0]   FULL = {1'b1, {TAG_W{1'b0}}};
    localparam logic [1:0]       K_ALU = 2'd0;
    localparam logic [1:0]       K_LONG = 2'd2;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [TAG_W-1:0] ytag_q [NREG];
    logic [TAG_W-1:0] ytag_d [NREG];
    logic [NREG-1:0]  rdy_q, rdy_d;
    logic [TAG_W-1:0] tag_q, tag_d, long_tag_q, long_tag_d;
    logic [TAG_W:0]   infl_q, infl_d;
    logic             long_busy_q, long_busy_d;
    logic             haz_j, haz_k, haz_d, sat, acc_w;
    logic             unused_wb_tag;

    // Retirement is tracked by register only; the tag is informational.
    assign unused_wb_tag = ^wb_tag;

    assign haz_j = use_rj && src_rj != 5'd0 && cnt_q[src_rj] != '0 && !rdy_q[src_rj];
    assign haz_k = use_rk && src_rk != 5'd0 && cnt_q[src_rk] != '0 && !rdy_q[src_rk];
    assign haz_d = use_rd && src_rd != 5'd0 && cnt_q[src_rd] != '0 && !rdy_q[src_rd];
    assign sat   = issue_wen && issue_rd != 5'd0 && cnt_q[issue_rd] == CMAX;
    assign stall = issue_valid && (haz_j || haz_k || haz_d || sat || infl_q == FULL ||
                                   (issue_kind == K_LONG && long_busy_q));
    assign acc_w = issue_valid && !stall && issue_wen && issue_rd != 5'd0;
    assign issue_tag = tag_q;
    assign inflight  = infl_q;

    always_comb begin
        cnt_d       = cnt_q;
        ytag_d      = ytag_q;
        rdy_d       = rdy_q;
        tag_d       = tag_q;
        infl_d      = infl_q;
        long_busy_d = long_busy_q;
        long_tag_d  = long_tag_q;
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_d[r]  = '0;
                ytag_d[r] = '0;
            end
            rdy_d       = '1;
            infl_d      = '0;
            long_busy_d = 1'b0;
        end else begin
            if (rdy_valid && rdy_rd != 5'd0 && rdy_tag == ytag_q[rdy_rd])
                rdy_d[rdy_rd] = 1'b1;
            if (rdy_valid && long_busy_q && rdy_tag == long_tag_q)
                long_busy_d = 1'b0;
            if (wb_valid && wb_rd != 5'd0 && cnt_q[wb_rd] != '0)
                cnt_d[wb_rd] = cnt_q[wb_rd] - 1'b1;
            if (wb_valid && infl_q != '0)
                infl_d = infl_q - 1'b1;
            // Issue is applied last so its rdy/ytag override same-cycle rdy/wb events.
            if (acc_w) begin
                cnt_d[issue_rd]  = cnt_d[issue_rd] + 1'b1;
                ytag_d[issue_rd] = tag_q;
                rdy_d[issue_rd]  = issue_kind == K_ALU;
                tag_d            = tag_q + 1'b1;
                infl_d           = infl_d + 1'b1;
                long_busy_d      = issue_kind == K_LONG ? 1'b1 : long_busy_d;
                long_tag_d       = issue_kind == K_LONG ? tag_q : long_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r]  <= '0;
                ytag_q[r] <= '0;
            end
            rdy_q       <= '1;
            tag_q       <= '0;
            infl_q      <= '0;
            long_busy_q <= 1'b0;
            long_tag_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ytag_q      <= ytag_d;
            rdy_q       <= rdy_d;
            tag_q       <= tag_d;
            infl_q      <= infl_d;
            long_busy_q <= long_busy_d;
            long_tag_q  <= long_tag_d;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed test-plan steps plus random traffic checked against
// a queue-based model of in-flight writers per register.
module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       reset, issue_valid, issue_wen, use_rj, use_rk, use_rd;
    logic [4:0] issue_rd, src_rj, src_rk, src_rd, rdy_rd, wb_rd;
    logic [1:0] issue_kind;
    logic       stall, rdy_valid, wb_valid, flush;
    logic [2:0] issue_tag, rdy_tag, wb_tag;
    logic [3:0] inflight;

    int errors = 0;
    int checks = 0;
    int mq[32][$];
    int mytag[32];
    bit mrdy[32];
    int mtag, minfl, mltag;
    bit mlb;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .issue_kind(issue_kind), .src_rj(src_rj), .src_rk(src_rk),
        .src_rd(src_rd), .use_rj(use_rj), .use_rk(use_rk), .use_rd(use_rd),
        .stall(stall), .issue_tag(issue_tag), .rdy_valid(rdy_valid), .rdy_tag(rdy_tag),
        .rdy_rd(rdy_rd), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_rd(wb_rd),
        .flush(flush), .inflight(inflight)
    );

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    function automatic bit haz(logic u, logic [4:0] s);
        return u && s != 0 && mq[s].size() > 0 && !mrdy[s];
    endfunction

    function automatic bit mstall();
        return issue_valid && (haz(use_rj, src_rj) || haz(use_rk, src_rk) || haz(use_rd, src_rd) ||
               (issue_wen && issue_rd != 0 && mq[issue_rd].size() == 3) || minfl == 8 ||
               (issue_kind == 2 && mlb));
    endfunction

    task automatic mclear();
        for (int r = 0; r < 32; r++) begin
            mq[r].delete();
            mytag[r] = 0;
            mrdy[r] = 1;
        end
        minfl = 0;
        mlb = 0;
    endtask

    task automatic idle();
        {issue_valid, issue_wen, use_rj, use_rk, use_rd, rdy_valid, wb_valid, flush} = '0;
        {issue_rd, src_rj, src_rk, src_rd, rdy_rd, wb_rd} = '0;
        {issue_kind, rdy_tag, wb_tag} = '0;
    endtask

    task automatic drive(bit wen, int rd, int kind, int rj);
        issue_valid = 1;
        issue_wen = wen;
        issue_rd = 5'(rd);
        issue_kind = 2'(kind);
        src_rj = 5'(rj);
        use_rj = rj != 0;
    endtask

    task automatic wb(int rd);
        wb_valid = 1;
        wb_rd = 5'(rd);
        wb_tag = 3'(mq[rd].size() > 0 ? mq[rd][0] : 0);
    endtask

    task automatic rdy(int rd, int tag);
        rdy_valid = 1;
        rdy_rd = 5'(rd);
        rdy_tag = 3'(tag);
    endtask

    // Check outputs against the model, advance the model by one clock, then step the DUT.
    task automatic cycle();
        bit st;
        #1;
        st = mstall();
        chk("stall", 32'(stall), 32'(st));
        chk("issue_tag", 32'(issue_tag), 32'(mtag));
        chk("inflight", 32'(inflight), 32'(minfl));
        if (flush) mclear();
        else begin
            if (rdy_valid && rdy_rd != 0 && int'(rdy_tag) == mytag[rdy_rd]) mrdy[rdy_rd] = 1;
            if (rdy_valid && mlb && int'(rdy_tag) == mltag) mlb = 0;
            if (wb_valid && mq[wb_rd].size() > 0) void'(mq[wb_rd].pop_front());
            if (wb_valid && minfl > 0) minfl--;
            if (issue_valid && !st && issue_wen && issue_rd != 0) begin
                mq[issue_rd].push_back(mtag);
                mytag[issue_rd] = mtag;
                mrdy[issue_rd] = issue_kind == 0;
                if (issue_kind == 2) begin
                    mlb = 1;
                    mltag = mtag;
                end
                mtag = (mtag + 1) % 8;
                minfl++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        mclear();
        mtag = 0;
        mltag = 0;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_tag", 32'(issue_tag), 0);
        chk("rst_infl", 32'(inflight), 0);
        // ALU producer is immediately bypassable
        drive(1, 5, 0, 0); cycle();
        drive(0, 0, 0, 5); #1 chk("alu_nostall", 32'(stall), 0); cycle();
        chk("alu_infl", 32'(inflight), 1);
        // LOAD blocks its consumer until rdy for its tag
        idle(); drive(1, 7, 1, 0); cycle();
        drive(0, 0, 0, 7); cycle(); cycle();
        rdy(7, 1); #1 chk("load_stall", 32'(stall), 1); cycle();
        rdy_valid = 0; #1 chk("load_go", 32'(stall), 0); cycle();
        // stale rdy for an older writer is ignored; ALU ready wins
        idle(); drive(1, 3, 1, 0); cycle();
        drive(1, 3, 0, 0); cycle();
        idle(); rdy(3, 2); cycle();
        idle(); drive(0, 0, 0, 3); #1 chk("r3_nostall", 32'(stall), 0); cycle();
        idle(); wb(3); cycle(); wb(3); cycle(); wb(5); cycle(); wb(7); cycle();
        idle(); #1 chk("drained", 32'(inflight), 0);
        // single long-latency unit
        drive(1, 4, 2, 0); cycle();
        drive(1, 9, 2, 0); #1 chk("long_stall", 32'(stall), 1); cycle(); cycle();
        rdy(4, 4); cycle();
        rdy_valid = 0; #1 chk("long_go", 32'(stall), 0); cycle();
        chk("long_tag", 32'(issue_tag), 6);
        idle(); rdy(9, 5); wb(4); cycle();
        idle(); wb(9); cycle();
        // per-register saturation and global in-flight limit
        idle(); drive(1, 2, 0, 0); cycle(); cycle(); cycle();
        #1 chk("sat_stall", 32'(stall), 1); cycle();
        for (int r = 10; r < 15; r++) begin
            drive(1, r, 0, 0); cycle();
        end
        drive(1, 15, 0, 0); #1 chk("full_stall", 32'(stall), 1); cycle();
        wb(2); cycle();
        wb_valid = 0; #1 chk("full_go", 32'(stall), 0); cycle();
        drive(1, 16, 0, 0); #1 chk("full_again", 32'(stall), 1); cycle();
        // flush clears tracking but keeps the tag counter
        idle(); flush = 1; cycle();
        idle(); drive(1, 1, 0, 0); cycle();
        drive(1, 6, 1, 0); cycle();
        idle(); flush = 1; cycle();
        idle();
        chk("flush_infl", 32'(inflight), 0);
        chk("flush_tag", 32'(issue_tag), 1);
        drive(0, 0, 0, 6); #1 chk("flush_r6", 32'(stall), 0); cycle();
        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            int r;
            idle();
            issue_valid = $urandom_range(3) != 0;
            issue_wen = $urandom_range(3) != 0;
            issue_rd = 5'($urandom_range(7));
            issue_kind = 2'($urandom_range(3));
            src_rj = 5'($urandom_range(7)); use_rj = 1'($urandom_range(1));
            src_rk = 5'($urandom_range(7)); use_rk = 1'($urandom_range(1));
            src_rd = 5'($urandom_range(7)); use_rd = 1'($urandom_range(1));
            r = $urandom_range(1, 7);
            if ($urandom_range(2) != 0)
                case ($urandom_range(2))
                    0: rdy(r, mq[r].size() > 0 ? mq[r][$] : 0);
                    1: rdy(r, mltag);
                    default: rdy(r, $urandom_range(7));
                endcase
            r = $urandom_range(1, 7);
            if (mq[r].size() > 0 && $urandom_range(2) != 0) wb(r);
            flush = $urandom_range(63) == 0;
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
